user_output_decoder: RTL and testbench
======================================

Name: user_output_decoder

Overview:
- Receiving end of the 2-bit UserOutput event code driven by the pixel-threshold inference logic: 01 = threshold hit (trigger), 10 = readout request, 00 = idle, 11 = illegal.
- Synchronizes and deglitches the code, then turns stable code changes into a one-cycle trigger pulse and a valid/ready request handshake.
- Also provides a trigger-to-request timeout, error/overrun flags and optional event counters.
- Sits in the CustomLogic clock domain, downstream of the I/O toolbox line carrying the code.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronized samples required to commit a code (1..255).
- TIMEOUT_CYC, 1024: max cycles from trigger commit to request commit; 0 disables the timeout.
- CNT_W, 16: event counter width.

Ports:
- clk  in  1  system clock
- aresetn  in  1  asynchronous active-low reset
- UserInput  in  2  event code, asynchronous to clk
- Request_rdy  in  1  downstream accepts request
- Clear_cnt  in  1  synchronous counter clear
- Trigger_pulse  out  1  one-cycle pulse on committed 01
- Request_vld  out  1  pending request
- Timeout_pulse  out  1  one-cycle pulse when no request follows a trigger in time
- Code_err  out  1  one-cycle pulse on committed 11
- Overrun  out  1  one-cycle pulse when a request is lost
- Stable_code  out  2  last committed legal code
- Trig_count  out  CNT_W  triggers seen (EVENT_COUNTERS_EN only)
- Req_count  out  CNT_W  requests accepted (EVENT_COUNTERS_EN only)

Behaviour:
- Reset (aresetn low, asynchronous):
  - Synchronizer flops, filter candidate, stable count, Stable_code, timeout counter and counters all cleared to 0.
  - All pulses and Request_vld are 0.
  - Reset taken mid-handshake drops the pending request with no Overrun.
- Synchronizer: two flops on UserInput.
- Filter:
  - If the synchronized code differs from the candidate, load the candidate and set the stable count to 1.
  - Otherwise increment the stable count, saturating.
  - Commit when the count reaches FILTER_LEN and the candidate differs from Stable_code.
  - Latency from an input change to the commit-cycle outputs: 2 + FILTER_LEN cycles.
  - Glitches shorter than FILTER_LEN cycles are never committed.
- Commit actions (registered, visible the cycle after the commit decision):
  - Commit 11: Code_err pulses; Stable_code stays unchanged.
  - Commit 01: Stable_code = 01; Trigger_pulse = 1 for one cycle; timeout counter loads 0 and arms.
  - Commit 10: Stable_code = 10; timeout disarms; request event raised.
  - Commit 00: Stable_code = 00; no pulse; timeout keeps running if armed.
- Request handshake, FSM with states R_IDLE and R_PEND:
  - R_IDLE, request event: go to R_PEND, Request_vld = 1.
  - R_PEND: Request_vld stays 1 until a cycle with Request_rdy = 1, then go to R_IDLE.
  - R_PEND, new request event without Request_rdy: Overrun pulses, the pending request is kept, the new one is dropped.
  - Accept and new request event in the same cycle: the old request is consumed, the new one becomes pending, Request_vld stays 1, no Overrun.
  - Request_vld never depends combinationally on Request_rdy.
- Timeout:
  - While armed, the counter increments each cycle.
  - On reaching TIMEOUT_CYC: Timeout_pulse = 1 for one cycle, then disarm.
  - A new 01 commit while armed restarts the count from 0.
  - TIMEOUT_CYC = 0: never armed, Timeout_pulse stays 0.
- Pulse outputs are 0 in every cycle where no event fires.

Optional Feature:
- Macro: USER_OUTPUT_DECODER_COUNTERS_EN (the "EVENT_COUNTERS_EN" referenced above).
- Defined:
  - Trig_count increments on each Trigger_pulse.
  - Req_count increments on each accepted handshake (Request_vld & Request_rdy).
  - Both are CNT_W-bit counters that saturate at all-ones.
  - Clear_cnt zeroes both and has priority over a same-cycle increment.
- Undefined:
  - Counter logic is removed; Trig_count and Req_count are tied to 0.
  - Clear_cnt is ignored.

Test Plan:
- Reset, then UserInput = 01 held 10 cycles (FILTER_LEN = 4) -> Trigger_pulse high exactly once, at cycle 6 after the change; Stable_code = 01; Trig_count = 1.
- UserInput pulses 10 for 3 cycles, then returns to 00 -> no commit, Request_vld stays 0, Stable_code unchanged.
- 01 then 10, each held 8 cycles, with Request_rdy low for 5 cycles then high -> Request_vld rises after the 10 commit, holds, drops the cycle after Request_rdy is sampled high; Req_count = 1; no Timeout_pulse.
- TIMEOUT_CYC = 20, UserInput = 01 held, no 10 -> Timeout_pulse exactly once, 20 cycles after the trigger commit; Request_vld stays 0.
- Pending request with Request_rdy = 0, then 00 -> 10 recommitted -> Overrun pulses once, Request_vld stays 1. Repeat with Request_rdy = 1 in the new-event cycle -> no Overrun, Request_vld stays 1.
- UserInput = 11 held 8 cycles -> Code_err pulses once, Stable_code keeps its prior value. Assert aresetn low during R_PEND -> Request_vld = 0 immediately. Clear_cnt together with a trigger -> counters read 0.

Source files
------------

// File: rtl/user_output_decoder.sv
// Decodes the 2-bit UserOutput event code: synchronize, deglitch, then emit trigger/request/timeout/error events.
// Optional saturating event counters are enabled with USER_OUTPUT_DECODER_COUNTERS_EN.
module user_output_decoder #(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic [1:0]       UserInput,
    input  logic             Request_rdy,
    input  logic             Clear_cnt,
    output logic             Trigger_pulse,
    output logic             Request_vld,
    output logic             Timeout_pulse,
    output logic             Code_err,
    output logic             Overrun,
    output logic [1:0]       Stable_code,
    output logic [CNT_W-1:0] Trig_count,
    output logic [CNT_W-1:0] Req_count
);
    localparam logic [7:0] FLEN = 8'(FILTER_LEN);
    localparam int         TW   = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {R_IDLE, R_PEND} req_state_t;

    logic [1:0]    sync1, sync2, cand;
    logic [7:0]    stab_cnt, stab_nxt;
    logic          commit, commit_trig, commit_req, commit_err;
    logic [TW-1:0] tcnt;
    logic          armed;
    req_state_t    rstate;

    // Decision is taken on the next-state count so that commit outputs land 2 + FILTER_LEN cycles after an input change.
    always_comb begin
        stab_nxt = 8'd1;
        if (sync2 == cand)
            stab_nxt = (stab_cnt == 8'hff) ? stab_cnt : stab_cnt + 8'd1;
        commit = (stab_nxt == FLEN)
              && !((sync2 == cand) && (stab_cnt == FLEN))
              && (sync2 != Stable_code);
        commit_trig = commit && (sync2 == 2'b01);
        commit_req  = commit && (sync2 == 2'b10);
        commit_err  = commit && (sync2 == 2'b11);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sync1    <= 2'b00;
            sync2    <= 2'b00;
            cand     <= 2'b00;
            stab_cnt <= 8'd0;
        end else begin
            sync1    <= UserInput;
            sync2    <= sync1;
            cand     <= sync2;
            stab_cnt <= stab_nxt;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            Stable_code   <= 2'b00;
            Trigger_pulse <= 1'b0;
            Code_err      <= 1'b0;
        end else begin
            Trigger_pulse <= commit_trig;
            Code_err      <= commit_err;
            if (commit && !commit_err)
                Stable_code <= sync2;
        end
    end

    // Trigger restarts the window, a request closes it; a committed 00 leaves it running.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            tcnt          <= '0;
            armed         <= 1'b0;
            Timeout_pulse <= 1'b0;
        end else begin
            Timeout_pulse <= 1'b0;
            if (commit_trig && (TIMEOUT_CYC != 0)) begin
                tcnt  <= '0;
                armed <= 1'b1;
            end else if (commit_req) begin
                armed <= 1'b0;
            end else if (armed) begin
                if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    Timeout_pulse <= 1'b1;
                    armed         <= 1'b0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rstate      <= R_IDLE;
            Request_vld <= 1'b0;
            Overrun     <= 1'b0;
        end else begin
            Overrun <= 1'b0;
            case (rstate)
                R_IDLE: begin
                    if (commit_req) begin
                        rstate      <= R_PEND;
                        Request_vld <= 1'b1;
                    end
                end
                R_PEND: begin
                    if (Request_rdy) begin
                        // Accept plus a new event in one cycle keeps the slot filled.
                        if (!commit_req) begin
                            rstate      <= R_IDLE;
                            Request_vld <= 1'b0;
                        end
                    end else if (commit_req) begin
                        Overrun <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef USER_OUTPUT_DECODER_COUNTERS_EN
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            Trig_count <= '0;
            Req_count  <= '0;
        end else if (Clear_cnt) begin
            Trig_count <= '0;
            Req_count  <= '0;
        end else begin
            if (Trigger_pulse && !(&Trig_count))
                Trig_count <= Trig_count + CNT_W'(1);
            if (Request_vld && Request_rdy && !(&Req_count))
                Req_count <= Req_count + CNT_W'(1);
        end
    end
`else
    logic unused_clear;
    assign unused_clear = Clear_cnt;
    assign Trig_count   = '0;
    assign Req_count    = '0;
`endif

endmodule

// File: tb/tb_user_output_decoder.sv
// Directed bench for user_output_decoder (FILTER_LEN=4, TIMEOUT_CYC=20); counter checks follow the build macro.
module tb_user_output_decoder;
    localparam int CNT_W = 16;
`ifdef USER_OUTPUT_DECODER_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk, aresetn, Request_rdy, Clear_cnt;
    logic [1:0]       UserInput;
    logic             Trigger_pulse, Request_vld, Timeout_pulse, Code_err, Overrun;
    logic [1:0]       Stable_code;
    logic [CNT_W-1:0] Trig_count, Req_count;

    user_output_decoder #(.FILTER_LEN(4), .TIMEOUT_CYC(20), .CNT_W(CNT_W)) dut (
        .clk(clk), .aresetn(aresetn), .UserInput(UserInput),
        .Request_rdy(Request_rdy), .Clear_cnt(Clear_cnt),
        .Trigger_pulse(Trigger_pulse), .Request_vld(Request_vld),
        .Timeout_pulse(Timeout_pulse), .Code_err(Code_err), .Overrun(Overrun),
        .Stable_code(Stable_code), .Trig_count(Trig_count), .Req_count(Req_count)
    );

    always #5 clk = ~clk;

    int tests, fails;
    int cyc, n_trig, n_to, n_err, n_ovr, n_vld, t_trig, t_to, t_vld;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cexp(input int v);
        return CNT_EN ? 32'(v) : 32'd0;
    endfunction

    task automatic clr_stats();
        cyc = 0; n_trig = 0; n_to = 0; n_err = 0; n_ovr = 0; n_vld = 0;
        t_trig = -1; t_to = -1; t_vld = -1;
    endtask

    // Advance n cycles, sampling 1 time unit after each rising edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (Trigger_pulse) begin n_trig++; t_trig = cyc; end
            if (Timeout_pulse) begin n_to++; t_to = cyc; end
            if (Code_err) n_err++;
            if (Overrun) n_ovr++;
            if (Request_vld) begin n_vld++; if (t_vld < 0) t_vld = cyc; end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        clk = 1'b0; aresetn = 1'b0; UserInput = 2'b00; Request_rdy = 1'b0; Clear_cnt = 1'b0;
        clr_stats();
        #12;
        chk("rst_trig", 32'(Trigger_pulse), 0);
        chk("rst_vld", 32'(Request_vld), 0);
        chk("rst_pulses", 32'({Timeout_pulse, Code_err, Overrun}), 0);
        chk("rst_stable", 32'(Stable_code), 0);
        chk("rst_cnt", 32'(Trig_count) + 32'(Req_count), 0);
        @(negedge clk) aresetn = 1'b1;
        run(10);

        // Trigger latency and timeout window
        clr_stats();
        UserInput = 2'b01;
        run(40);
        chk("trig_once", n_trig, 1);
        chk("trig_lat", t_trig, 6);
        chk("to_once", n_to, 1);
        chk("to_lat", t_to, 26);
        chk("to_no_vld", n_vld, 0);
        chk("stable_01", 32'(Stable_code), 1);
        chk("trig_cnt1", 32'(Trig_count), cexp(1));

        // Commit 00 silently, then a 3-cycle glitch of 10
        clr_stats();
        UserInput = 2'b00;
        run(8);
        chk("stable_00", 32'(Stable_code), 0);
        chk("idle_pulses", n_trig + n_err + n_to, 0);
        clr_stats();
        UserInput = 2'b10;
        run(3);
        UserInput = 2'b00;
        run(12);
        chk("glitch_vld", n_vld, 0);
        chk("glitch_stable", 32'(Stable_code), 0);

        // Trigger then request, downstream stalls 5 cycles
        clr_stats();
        UserInput = 2'b01;
        run(8);
        UserInput = 2'b10;
        run(11);
        chk("vld_rise", t_vld, 14);
        chk("vld_hold", n_vld, 6);
        Request_rdy = 1'b1;
        run(1);
        Request_rdy = 1'b0;
        chk("vld_drop", 32'(Request_vld), 0);
        chk("stable_10", 32'(Stable_code), 2);
        chk("trig_cnt2", 32'(Trig_count), cexp(2));
        chk("req_cnt1", 32'(Req_count), cexp(1));

        // Overrun on a second request while one is pending
        n_ovr = 0;
        UserInput = 2'b00; run(6);
        UserInput = 2'b10; run(6);
        chk("vld_pend", 32'(Request_vld), 1);
        UserInput = 2'b00; run(6);
        UserInput = 2'b10; run(6);
        chk("ovr_once", n_ovr, 1);
        chk("ovr_vld", 32'(Request_vld), 1);

        // Same again but accepted in the new-event cycle
        n_ovr = 0;
        UserInput = 2'b00; run(6);
        UserInput = 2'b10; run(5);
        Request_rdy = 1'b1;
        run(1);
        Request_rdy = 1'b0;
        chk("acc_no_ovr", n_ovr, 0);
        chk("acc_vld", 32'(Request_vld), 1);
        chk("req_cnt2", 32'(Req_count), cexp(2));
        chk("no_timeout", n_to, 0);

        // Illegal code
        n_err = 0;
        UserInput = 2'b11;
        run(8);
        chk("err_once", n_err, 1);
        chk("err_stable", 32'(Stable_code), 2);

        // Asynchronous reset while a request is pending
        chk("pre_rst_vld", 32'(Request_vld), 1);
        @(negedge clk) aresetn = 1'b0;
        #1;
        chk("arst_vld", 32'(Request_vld), 0);
        chk("arst_ovr", 32'(Overrun), 0);
        chk("arst_stable", 32'(Stable_code), 0);
        UserInput = 2'b00;
        @(negedge clk) aresetn = 1'b1;
        run(10);

        // Clear has priority over a same-cycle counter increment
        clr_stats();
        UserInput = 2'b01;
        run(6);
        chk("clr_trig", 32'(Trigger_pulse), 1);
        Clear_cnt = 1'b1;
        run(1);
        Clear_cnt = 1'b0;
        chk("clr_tcnt", 32'(Trig_count), 0);
        chk("clr_rcnt", 32'(Req_count), 0);
        run(3);
        chk("clr_tcnt_after", 32'(Trig_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
